qtcore_scan_sequencer: RTL and testbench
========================================

// Module: qtcore_scan_sequencer
// PURPOSE
//  Host-side sequencer for the accumulator microcontroller's scan chain and run control.
//  Accepts a program/state image as a byte stream and serialises it into the core's scan chain.
//  Then releases the core (proc_en) until it halts or a watchdog expires.
//  Sits between the SPI/byte front end and the core; it owns scan_enable, scan_in and proc_en.
// PARAMETERS
//  SCAN_LEN    160   total scan-chain length in bits; image is ceil(SCAN_LEN/8) bytes
//  CYCLE_LIMIT 4096  max proc_en cycles before timeout; counter is $clog2(CYCLE_LIMIT+1) bits
// PORTS
//  clk          in   1  system clock, all logic rising-edge
//  rst          in   1  synchronous, active-high reset
//  start        in   1  begin load+run; sampled only in IDLE or DONE
//  byte_data    in   8  image byte, shifted MSB first
//  byte_valid   in   1  byte_data valid
//  byte_ready   out  1  sequencer accepts byte when valid&&ready
//  scan_enable  out  1  to core: shift chain this cycle
//  scan_in      out  1  to core: serial data
//  scan_out     in   1  from core: serial chain output
//  proc_en      out  1  to core: execute
//  halt         in   1  from core: program halted
//  busy         out  1  high in LOAD or RUN
//  done         out  1  high in DONE
//  timeout      out  1  DONE was reached by watchdog, not halt
//  rb_data      out  8  readback byte (READBACK_EN)
//  rb_valid     out  1  one-cycle strobe for rb_data (READBACK_EN)
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; all counters cleared. Reset mid-LOAD/RUN aborts immediately.
//  - IDLE: start=1 -> LOAD, bit counter=0.
//  - LOAD: byte_ready=1 only when internal shift register is empty and bits remain.
//    - Accepted byte is shifted out over the following 8 cycles, MSB first.
//    - Each shift cycle: scan_enable=1, scan_in=current bit.
//    - No byte pending: scan_enable=0 (chain holds). Accept-to-first-shift latency is 1 cycle.
//    - Back-to-back bytes give a gapless scan_enable.
//    - Final byte when SCAN_LEN%8!=0: only its top SCAN_LEN%8 bits shift; the rest are discarded.
//    - After shift SCAN_LEN completes: scan_enable=0 next cycle and state -> RUN.
//    - Exactly SCAN_LEN scan_enable cycles per load.
//  - RUN: proc_en=1 and the cycle counter increments each cycle.
//    - halt=1 -> DONE, timeout=0.
//    - Counter reaches CYCLE_LIMIT with no halt -> DONE, timeout=1.
//    - halt and limit in the same cycle: halt wins (timeout=0).
//    - proc_en drops in the same cycle DONE is entered.
//  - DONE: done=1 and timeout held until the next start. start -> LOAD, clearing done and timeout.
//  - start is ignored in LOAD and RUN. byte_valid is ignored outside LOAD (byte_ready=0).
//  - scan_enable and proc_en are never high together.
// CONFIGURATION
//  READBACK_EN defined:
//    - During LOAD, scan_out is sampled on every shift cycle into a capture register.
//    - Bit order: first bit sampled -> MSB.
//    - After every 8 samples, rb_valid pulses 1 cycle with rb_data.
//    - A partial final group is left-aligned, zero-filled, and strobed on the last shift.
//    - Result: the previous chain contents (prior run's final state) stream out while the new image loads.
//  READBACK_EN undefined: no capture logic; rb_data=0, rb_valid=0; ports still present.
// STRUCTURE
//  - Package qtcore_seq_pkg: state encoding (IDLE, LOAD, RUN, DONE), SCAN_BYTES=ceil(SCAN_LEN/8) helper, byte width constant.
//  - Sub-module qtcore_scan_serializer: 8-bit load/shift register with empty flag and bits-to-send count (handles partial final byte).
//  - Top holds the FSM, bit counter, watchdog and readback capture.
// TESTING
//  1. Reset mid-LOAD after 37 shifts -> next cycle all outputs 0, state IDLE; new start reloads from bit 0.
//  2. SCAN_LEN=160, 20 bytes streamed back-to-back -> 160 contiguous scan_enable cycles, scan_in matches MSB-first bits; proc_en rises the cycle after the last shift.
//  3. byte_valid dropped for 5 cycles mid-image -> scan_enable low exactly those stall cycles; total shifts still 160.
//  4. SCAN_LEN=150 -> 19 bytes accepted; final byte shifts 6 bits; byte_ready stays 0 after the 19th byte.
//  5. halt asserted at RUN cycle 10 -> done=1, timeout=0, proc_en high exactly 10 cycles. halt never, CYCLE_LIMIT=16 -> timeout=1 after 16 cycles.
//  6. READBACK_EN, chain preloaded 0xA5... -> rb_valid strobes every 8 shifts with 0xA5; without macro rb_valid never rises.

Source files
------------

// File: rtl/qtcore_seq_pkg.sv
// Shared types and constants for the qtcore scan/run sequencer: state encoding,
// byte geometry and the image-size helper.
package qtcore_seq_pkg;

  localparam int BYTE_W          = 8;
  localparam int BIT_CNT_W       = $clog2(BYTE_W + 1);
  localparam int DEF_SCAN_LEN    = 160;
  localparam int DEF_CYCLE_LIMIT = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  // Number of image bytes needed to cover a scan chain of scan_len bits.
  function automatic int scan_bytes(input int scan_len);
    return (scan_len + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/qtcore_scan_serializer.sv
// Byte-to-bit serializer: loads a byte with a bit budget (1..8) and shifts it
// out MSB first, one bit per cycle, while the budget is non-zero.
module qtcore_scan_serializer
  import qtcore_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [BYTE_W-1:0]    load_data,
  input  logic [BIT_CNT_W-1:0] load_bits,
  output logic                 empty,
  output logic                 shifting,
  output logic                 bit_out
);

  logic [BYTE_W-1:0]    sreg_q, sreg_d;
  logic [BIT_CNT_W-1:0] bits_left_q, bits_left_d;

  // "Empty" already holds while the last bit is on the wire, so a byte accepted
  // that cycle starts shifting immediately after and the stream stays gapless.
  assign empty    = (bits_left_q <= BIT_CNT_W'(1));
  assign shifting = (bits_left_q != '0);
  assign bit_out  = sreg_q[BYTE_W-1];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    sreg_d      = sreg_q;
    bits_left_d = bits_left_q;
    if (shifting) begin
      sreg_d      = {sreg_q[BYTE_W-2:0], 1'b0};
      bits_left_d = bits_left_q - BIT_CNT_W'(1);
    end
    if (load) begin
      sreg_d      = load_data;
      bits_left_d = load_bits;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q      <= '0;
      bits_left_q <= '0;
    end else begin
      sreg_q      <= sreg_d;
      bits_left_q <= bits_left_d;
    end
  end

endmodule

// File: rtl/qtcore_scan_sequencer.sv
// Loads a byte-stream image into the core's scan chain, then runs the core
// until halt or watchdog. Optional chain readback is enabled by READBACK_EN.
module qtcore_scan_sequencer
  import qtcore_seq_pkg::*;
#(
  parameter int SCAN_LEN    = DEF_SCAN_LEN,
  parameter int CYCLE_LIMIT = DEF_CYCLE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              scan_enable,
  output logic              scan_in,
  input  logic              scan_out,
  output logic              proc_en,
  input  logic              halt,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [BYTE_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int NBYTES     = scan_bytes(SCAN_LEN);
  localparam int TAIL_BITS  = SCAN_LEN % BYTE_W;
  localparam int SHIFT_W    = $clog2(SCAN_LEN + 1);
  localparam int BYTE_CNT_W = $clog2(NBYTES + 1);
  localparam int CYC_W      = $clog2(CYCLE_LIMIT + 1);

  localparam logic [SHIFT_W-1:0]    LAST_SHIFT = SHIFT_W'(SCAN_LEN - 1);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE  = BYTE_CNT_W'(NBYTES - 1);
  localparam logic [BYTE_CNT_W-1:0] ALL_BYTES  = BYTE_CNT_W'(NBYTES);
  localparam logic [CYC_W-1:0]      LIMIT      = CYC_W'(CYCLE_LIMIT);
  localparam logic [BIT_CNT_W-1:0]  FULL_BITS  = BIT_CNT_W'(BYTE_W);
  localparam logic [BIT_CNT_W-1:0]  TAIL_CNT   =
      (TAIL_BITS == 0) ? BIT_CNT_W'(BYTE_W) : BIT_CNT_W'(TAIL_BITS);

  seq_state_e            state_q, state_d;
  logic [SHIFT_W-1:0]    shift_cnt_q, shift_cnt_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CYC_W-1:0]      cyc_cnt_q, cyc_cnt_d;
  logic                  timeout_q, timeout_d;

  logic                  ser_load;
  logic [BIT_CNT_W-1:0]  ser_bits;
  logic                  ser_empty, ser_shifting, ser_bit;

  qtcore_scan_serializer u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_data (byte_data),
    .load_bits (ser_bits),
    .empty     (ser_empty),
    .shifting  (ser_shifting),
    .bit_out   (ser_bit)
  );

  assign scan_enable = (state_q == LOAD) && ser_shifting;
  assign scan_in     = scan_enable & ser_bit;
  assign proc_en     = (state_q == RUN);
  assign busy        = (state_q == LOAD) || (state_q == RUN);
  assign done        = (state_q == DONE);
  assign timeout     = timeout_q;

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    timeout_d   = timeout_q;
    byte_ready  = 1'b0;
    ser_load    = 1'b0;
    ser_bits    = FULL_BITS;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = LOAD;
          shift_cnt_d = '0;
          byte_cnt_d  = '0;
          cyc_cnt_d   = '0;
          timeout_d   = 1'b0;
        end
      end

      LOAD: begin
        byte_ready = ser_empty && (byte_cnt_q != ALL_BYTES);
        if (byte_valid && byte_ready) begin
          ser_load   = 1'b1;
          byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
          // Only the top bits of a short final byte belong to the chain.
          ser_bits   = (byte_cnt_q == LAST_BYTE) ? TAIL_CNT : FULL_BITS;
        end
        if (ser_shifting) begin
          shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
          if (shift_cnt_q == LAST_SHIFT) state_d = RUN;
        end
      end

      RUN: begin
        cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        // halt is tested first so it wins a tie with the watchdog.
        if (halt) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if (cyc_cnt_d == LIMIT) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_cnt_q <= '0;
      byte_cnt_q  <= '0;
      cyc_cnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef READBACK_EN
  // Captures the old chain contents as they fall out of scan_out during LOAD.
  logic [BYTE_W-1:0] cap_q, cap_d, cap_next;
  logic [2:0]        cap_cnt_q, cap_cnt_d;
  logic [BYTE_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;

  always_comb begin
    cap_d      = cap_q;
    cap_cnt_d  = cap_cnt_q;
    cap_next   = {cap_q[BYTE_W-2:0], scan_out};
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    if (scan_enable) begin
      cap_d     = cap_next;
      cap_cnt_d = cap_cnt_q + 3'd1;
      if ((cap_cnt_q == 3'd7) || (shift_cnt_q == LAST_SHIFT)) begin
        rb_data_d  = cap_next << (3'd7 - cap_cnt_q);
        rb_valid_d = 1'b1;
        cap_cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q      <= '0;
      cap_cnt_q  <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      cap_cnt_q  <= cap_cnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_scan_out;
  assign unused_scan_out = scan_out;
  assign rb_data         = '0;
  assign rb_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_qtcore_scan_sequencer.sv
// Randomized bench for qtcore_scan_sequencer: two instances (160/4096 and
// 150/16) against a bit-stream reference model with a modelled core chain.
module tb_qtcore_scan_sequencer;

  localparam int LEN_A = 160, LIM_A = 4096;
  localparam int LEN_B = 150, LIM_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, byte_valid = 1'b0, halt = 1'b0;
  logic       preload = 1'b1, sel = 1'b0;
  logic [7:0] byte_data = '0;
  logic       start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start &  sel;

  logic       br_a, se_a, si_a, so_a, pe_a, busy_a, done_a, to_a, rbv_a;
  logic       br_b, se_b, si_b, so_b, pe_b, busy_b, done_b, to_b, rbv_b;
  logic [7:0] rbd_a, rbd_b;

  qtcore_scan_sequencer #(.SCAN_LEN(LEN_A), .CYCLE_LIMIT(LIM_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(br_a), .scan_enable(se_a),
    .scan_in(si_a), .scan_out(so_a), .proc_en(pe_a), .halt(halt),
    .busy(busy_a), .done(done_a), .timeout(to_a), .rb_data(rbd_a),
    .rb_valid(rbv_a));

  qtcore_scan_sequencer #(.SCAN_LEN(LEN_B), .CYCLE_LIMIT(LIM_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(br_b), .scan_enable(se_b),
    .scan_in(si_b), .scan_out(so_b), .proc_en(pe_b), .halt(halt),
    .busy(busy_b), .done(done_b), .timeout(to_b), .rb_data(rbd_b),
    .rb_valid(rbv_b));

  // Core scan chains: shift toward the MSB end, which drives scan_out.
  function automatic logic [LEN_A-1:0] a5_fill();
    logic [7:0]       pat = 8'hA5;
    logic [LEN_A-1:0] v;
    for (int j = 0; j < LEN_A; j++) v[LEN_A-1-j] = pat[7 - (j % 8)];
    return v;
  endfunction

  logic [LEN_A-1:0] chain_a;
  logic [LEN_B-1:0] chain_b;
  logic [LEN_A-1:0] fill_v;
  assign fill_v = a5_fill();
  assign so_a   = chain_a[LEN_A-1];
  assign so_b   = chain_b[LEN_B-1];

  always @(posedge clk) begin
    if (preload) begin
      chain_a <= fill_v;
      chain_b <= fill_v[LEN_A-1 -: LEN_B];
    end else begin
      if (se_a) chain_a <= {chain_a[LEN_A-2:0], si_a};
      if (se_b) chain_b <= {chain_b[LEN_B-2:0], si_b};
    end
  end

  logic       br_s, se_s, si_s, pe_s, busy_s, done_s, to_s, rbv_s;
  logic [7:0] rbd_s;
  assign br_s   = sel ? br_b   : br_a;
  assign se_s   = sel ? se_b   : se_a;
  assign si_s   = sel ? si_b   : si_a;
  assign pe_s   = sel ? pe_b   : pe_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign to_s   = sel ? to_b   : to_a;
  assign rbv_s  = sel ? rbv_b  : rbv_a;
  assign rbd_s  = sel ? rbd_b  : rbd_a;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor on the selected instance; a start seen while not busy opens a new session.
  int         cyc = 0, shifts, gaps, acc, ready_extra, mutex_err, pen_cnt, first_pen, last_shift;
  bit         scan_q[$];
  logic [7:0] rb_q[$];
  int         nb_cur;
  assign nb_cur = sel ? (LEN_B + 7) / 8 : (LEN_A + 7) / 8;

  always @(negedge clk) begin
    cyc++;
    if (start && !busy_s) begin
      shifts = 0; gaps = 0; acc = 0; ready_extra = 0; mutex_err = 0;
      pen_cnt = 0; first_pen = -1; last_shift = -1;
      scan_q.delete(); rb_q.delete();
    end else begin
      if (br_s && acc >= nb_cur) ready_extra++;
      if (br_s && byte_valid) acc++;
      if (se_s) begin
        shifts++;
        last_shift = cyc;
        scan_q.push_back(si_s);
      end else if (busy_s && !pe_s && shifts > 0) begin
        gaps++;
      end
      if (pe_s) begin
        if (pen_cnt == 0) first_pen = cyc;
        pen_cnt++;
      end
      if (se_s && pe_s) mutex_err++;
      if (rbv_s) rb_q.push_back(rbd_s);
    end
  end

  // Chain contents as seen from scan_out, first bit out first.
  bit prev [2][$];

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    do begin @(negedge clk); guard++; end while (!br_s && guard < 64);
    if (!br_s) check(tag, 0, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    wait_ready("byte_ready_wait");
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic run_session(input int u, input int stall_after, input int halt_at, input bit poke);
    int         len   = u ? LEN_B : LEN_A;
    int         lim   = u ? LIM_B : LIM_A;
    int         nb    = (len + 7) / 8;
    string      tg    = $sformatf("%s%0d", u ? "B" : "A", cyc);
    logic [7:0] img[$];
    bit         exp_bits[$];
    int         bad, n, guard, exp_pen;
    bit         exp_to;

    @(posedge clk); #1;
    sel = u[0];
    for (int k = 0; k < nb; k++) img.push_back(8'($urandom));
    for (int j = 0; j < len; j++) exp_bits.push_back(img[j/8][7 - (j % 8)]);

    pulse_start();
    for (int k = 0; k < nb; k++) begin
      if (stall_after >= 0 && k == stall_after + 1) begin
        wait_ready({tg, "_stall_wait"});
        repeat (5) @(posedge clk);
        #1;
      end
      send_byte(img[k]);
    end

    n = 0; guard = 0;
    while (!done_s && guard < lim + 300) begin
      @(negedge clk); guard++;
      if (done_s) break;
      if (pe_s) begin
        n++;
        halt  = (n == halt_at);
        start = poke && (n == 2);
      end else begin
        halt  = 1'b0;
        start = 1'b0;
      end
    end
    halt = 1'b0; start = 1'b0;
    #1;

    exp_to  = !(halt_at > 0 && halt_at <= lim);
    exp_pen = exp_to ? lim : halt_at;
    check({tg, "_done"},       done_s, 1);
    check({tg, "_proc_off"},   pe_s, 0);
    check({tg, "_timeout"},    to_s, exp_to);
    check({tg, "_proc_cyc"},   pen_cnt, exp_pen);
    check({tg, "_shifts"},     shifts, len);
    check({tg, "_bytes"},      acc, nb);
    bad = (scan_q.size() == exp_bits.size()) ? 0 : 1;
    for (int j = 0; j < len && j < scan_q.size(); j++) if (scan_q[j] != exp_bits[j]) bad++;
    check({tg, "_scan_bits"},  bad, 0);
    check({tg, "_gaps"},       gaps, (stall_after >= 0) ? 5 : 0);
    check({tg, "_run_lat"},    first_pen - last_shift, 1);
    check({tg, "_ready_late"}, ready_extra, 0);
    check({tg, "_mutex"},      mutex_err, 0);
`ifdef READBACK_EN
    check({tg, "_rb_count"}, rb_q.size(), nb);
    for (int g = 0; g < nb; g++) begin
      logic [7:0] e = '0;
      for (int i = 0; i < 8; i++) if (8*g + i < len) e[7-i] = prev[u][8*g + i];
      check($sformatf("%s_rb%0d", tg, g), (g < rb_q.size()) ? rb_q[g] : 8'hxx, e);
    end
`else
    check({tg, "_rb_none"}, rb_q.size(), 0);
`endif
    prev[u] = exp_bits;
  endtask

  task automatic abort_session(input int u, input int at);
    int         len = u ? LEN_B : LEN_A;
    logic [7:0] img[$];
    bit         newp[$];
    int         guard = 0, bad = 0;

    @(posedge clk); #1;
    sel = u[0];
    for (int k = 0; k < (at + 7) / 8; k++) img.push_back(8'($urandom));
    pulse_start();
    for (int k = 0; k < img.size(); k++) send_byte(img[k]);
    do begin @(negedge clk); #1; guard++; end while (shifts < at && guard < 100);
    check("abort_shifts", shifts, at);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs",
          {br_s, se_s, si_s, pe_s, busy_s, done_s, to_s, rbv_s, rbd_s}, '0);
    for (int j = 0; j < at; j++) if (scan_q[j] != img[j/8][7 - (j % 8)]) bad++;
    check("abort_bits", bad, 0);
    #1 rst = 1'b0;
    for (int j = at; j < len; j++) newp.push_back(prev[u][j]);
    for (int j = 0; j < at; j++) newp.push_back(img[j/8][7 - (j % 8)]);
    prev[u] = newp;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat = 8'hA5;
    for (int j = 0; j < LEN_A; j++) prev[0].push_back(pat[7 - (j % 8)]);
    for (int j = 0; j < LEN_B; j++) prev[1].push_back(pat[7 - (j % 8)]);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", {br_a, se_a, si_a, pe_a, busy_a, done_a, to_a, rbv_a, rbd_a}, '0);
    check("reset_b", {br_b, se_b, si_b, pe_b, busy_b, done_b, to_b, rbv_b, rbd_b}, '0);
    rst = 1'b0; preload = 1'b0;

    run_session(0, -1, 10, 1'b0);
    run_session(0, int'($urandom_range(0, 17)), int'($urandom_range(1, 40)), 1'b1);
    abort_session(0, 37);
    run_session(0, -1, int'($urandom_range(1, 40)), 1'b0);
    run_session(0, -1, 0, 1'b0);
    run_session(1, -1, 0, 1'b0);
    run_session(1, -1, LIM_B, 1'b0);
    run_session(1, int'($urandom_range(0, 16)), int'($urandom_range(1, 15)), 1'b1);
    for (int r = 0; r < 3; r++)
      run_session(1, int'($urandom_range(0, 17)) - 1, int'($urandom_range(0, LIM_B)),
                  1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
